// File: rtl/multi_cycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath: holds the instruction in IR,
// steps FETCH/DECODE/EXEC/MEM/WB and drives state-qualified control words and strobes.
module multi_cycle_control #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int RETIRE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             im_rdata,
    input  logic                    im_ready,
    input  logic                    dm_ready,
    output logic                    im_req,
    output logic                    dm_req,
    output logic                    cw_pc_enable,
    output logic                    cw_im_enable,
    output logic [4:0]              cw_rf_read_addr1,
    output logic [4:0]              cw_rf_read_addr2,
    output logic [4:0]              cw_rf_write_addr,
    output logic [1:0]              cm_rf_write_data,
    output logic                    cm_alu_num2,
    output logic [2:0]              cw_npc_jump_mode,
    output logic                    cw_rf_write_enable,
    output logic [4:0]              cw_alu_op,
    output logic [2:0]              cw_ext_mode,
    output logic                    cw_dm_write_enable,
    output logic [2:0]              state,
    output logic                    illegal_instr,
    output logic                    retire,
    output logic [RETIRE_WIDTH-1:0] retire_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_LUI, I_ORI, I_LW, I_SW,
        I_BEQ, I_JAL, I_JR, I_JALR, I_UNKNOWN
    } instr_t;

    localparam logic [1:0] WD_ALU_RESULT     = 2'd0;
    localparam logic [1:0] WD_DM_READ_RESULT = 2'd1;
    localparam logic [1:0] WD_PC_ADD_4       = 2'd2;
    localparam logic       NUM2_RF           = 1'b0;
    localparam logic       NUM2_EXT          = 1'b1;
    localparam logic [2:0] JUMP_DISABLED     = 3'd0;
    localparam logic [2:0] JUMP_WHEN_EQUAL   = 3'd1;
    localparam logic [2:0] JUMP_JNUM         = 3'd2;
    localparam logic [2:0] JUMP_REG          = 3'd3;
    localparam logic [4:0] ALU_ADD           = 5'd0;
    localparam logic [4:0] ALU_SUB           = 5'd1;
    localparam logic [4:0] ALU_OR            = 5'd2;
    localparam logic [2:0] EXT_UNSIGNED      = 3'd0;
    localparam logic [2:0] EXT_PAD           = 3'd1;
    localparam logic [2:0] EXT_SIGNED        = 3'd2;

    localparam int WAIT_CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [WAIT_CW-1:0] WAIT_LIMIT = WAIT_CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    state_t               state_q;
    logic [31:0]          ir;
    logic [WAIT_CW-1:0]   wait_cnt;
    instr_t               instr;
    logic                 timeout_hit;
    logic                 active;
    logic                 exec_retire;
    logic                 sw_done;
    logic [4:0]           dec_wa;
    logic [1:0]           dec_wd;
    logic                 dec_num2;
    logic [2:0]           dec_jump;
    logic [4:0]           dec_alu;
    logic [2:0]           dec_ext;
    logic                 unused_shamt;

    assign unused_shamt = ^ir[10:6];

    always_comb begin
        instr = I_UNKNOWN;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h00:   instr = I_NOP;
                    6'h21:   instr = I_ADDU;
                    6'h23:   instr = I_SUBU;
                    6'h08:   instr = I_JR;
                    6'h09:   instr = I_JALR;
                    default: instr = I_UNKNOWN;
                endcase
            end
            6'h0f:   instr = I_LUI;
            6'h0d:   instr = I_ORI;
            6'h23:   instr = I_LW;
            6'h2b:   instr = I_SW;
            6'h04:   instr = I_BEQ;
            6'h03:   instr = I_JAL;
            default: instr = I_UNKNOWN;
        endcase
    end

    always_comb begin
        dec_wa   = ir[20:16];
        dec_wd   = WD_ALU_RESULT;
        dec_num2 = NUM2_RF;
        dec_jump = JUMP_DISABLED;
        dec_alu  = ALU_OR;
        dec_ext  = EXT_UNSIGNED;
        case (instr)
            I_ADDU: begin dec_wa = ir[15:11]; dec_alu = ALU_ADD; end
            I_SUBU: begin dec_wa = ir[15:11]; dec_alu = ALU_SUB; end
            I_LUI:  begin dec_ext = EXT_PAD; dec_num2 = NUM2_EXT; end
            I_ORI:  dec_num2 = NUM2_EXT;
            I_LW: begin
                dec_wd   = WD_DM_READ_RESULT;
                dec_alu  = ALU_ADD;
                dec_ext  = EXT_SIGNED;
                dec_num2 = NUM2_EXT;
            end
            I_SW: begin dec_alu = ALU_ADD; dec_ext = EXT_SIGNED; dec_num2 = NUM2_EXT; end
            I_BEQ:  dec_jump = JUMP_WHEN_EQUAL;
            I_JAL:  begin dec_wa = 5'd31; dec_wd = WD_PC_ADD_4; dec_jump = JUMP_JNUM; end
            I_JALR: begin dec_wa = ir[15:11]; dec_wd = WD_PC_ADD_4; dec_jump = JUMP_REG; end
            I_JR:   dec_jump = JUMP_REG;
            default: ;
        endcase
    end

    // Decoded selects only leave their defaults once IR holds the current instruction.
    assign active           = (state_q == DECODE) || (state_q == EXEC) ||
                              (state_q == MEM) || (state_q == WB);
    assign cw_rf_write_addr = active ? dec_wa   : ir[20:16];
    assign cm_rf_write_data = active ? dec_wd   : WD_ALU_RESULT;
    assign cm_alu_num2      = active ? dec_num2 : NUM2_RF;
    assign cw_npc_jump_mode = active ? dec_jump : JUMP_DISABLED;
    assign cw_alu_op        = active ? dec_alu  : ALU_OR;
    assign cw_ext_mode      = active ? dec_ext  : EXT_UNSIGNED;
    assign cw_rf_read_addr1 = ir[25:21];
    assign cw_rf_read_addr2 = ir[20:16];

    assign exec_retire = (state_q == EXEC) &&
                         (instr == I_BEQ || instr == I_JR || instr == I_NOP ||
                          instr == I_UNKNOWN || instr == I_JAL || instr == I_JALR);
    assign sw_done     = (state_q == MEM) && dm_ready && (instr == I_SW);

    assign im_req             = (state_q == FETCH);
    assign cw_im_enable       = im_req;
    assign dm_req             = (state_q == MEM);
    assign retire             = exec_retire || sw_done || (state_q == WB);
    assign cw_pc_enable       = retire;
    assign cw_dm_write_enable = sw_done;
    assign cw_rf_write_enable = (state_q == WB) ||
                                ((state_q == EXEC) && (instr == I_JAL || instr == I_JALR));
    assign illegal_instr      = (state_q == EXEC) && (instr == I_UNKNOWN);
    assign state              = state_q;

    // A ready seen in the would-be timeout cycle takes priority over halting.
    assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            ir           <= '0;
            wait_cnt     <= '0;
            retire_count <= '0;
        end else begin
            if (retire)
                retire_count <= retire_count + RETIRE_WIDTH'(1);
            wait_cnt <= '0;
            case (state_q)
                FETCH: begin
                    if (im_ready) begin
                        ir      <= im_rdata;
                        state_q <= DECODE;
                    end else if (timeout_hit) begin
                        state_q <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CW'(1);
                    end
                end
                DECODE: state_q <= EXEC;
                EXEC: begin
                    case (instr)
                        I_ADDU, I_SUBU, I_LUI, I_ORI: state_q <= WB;
                        I_LW, I_SW:                   state_q <= MEM;
                        default:                      state_q <= FETCH;
                    endcase
                end
                MEM: begin
                    if (dm_ready)
                        state_q <= (instr == I_LW) ? WB : FETCH;
                    else if (timeout_hit)
                        state_q <= HALT;
                    else
                        wait_cnt <= wait_cnt + WAIT_CW'(1);
                end
                WB:      state_q <= FETCH;
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control: one task per scenario,
// every expected value hand-derived from the instruction encodings.
module tb_multi_cycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] im_rdata = '0;
    logic        im_ready = 1'b0;
    logic        dm_ready = 1'b0;
    logic        im_req, dm_req, cw_pc_enable, cw_im_enable;
    logic [4:0]  cw_rf_read_addr1, cw_rf_read_addr2, cw_rf_write_addr;
    logic [1:0]  cm_rf_write_data;
    logic        cm_alu_num2;
    logic [2:0]  cw_npc_jump_mode;
    logic        cw_rf_write_enable;
    logic [4:0]  cw_alu_op;
    logic [2:0]  cw_ext_mode;
    logic        cw_dm_write_enable;
    logic [2:0]  state;
    logic        illegal_instr, retire;
    logic [31:0] retire_count;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_retire = '0;

    multi_cycle_control #(.WAIT_TIMEOUT(16), .RETIRE_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .im_rdata(im_rdata), .im_ready(im_ready),
        .dm_ready(dm_ready), .im_req(im_req), .dm_req(dm_req),
        .cw_pc_enable(cw_pc_enable), .cw_im_enable(cw_im_enable),
        .cw_rf_read_addr1(cw_rf_read_addr1), .cw_rf_read_addr2(cw_rf_read_addr2),
        .cw_rf_write_addr(cw_rf_write_addr), .cm_rf_write_data(cm_rf_write_data),
        .cm_alu_num2(cm_alu_num2), .cw_npc_jump_mode(cw_npc_jump_mode),
        .cw_rf_write_enable(cw_rf_write_enable), .cw_alu_op(cw_alu_op),
        .cw_ext_mode(cw_ext_mode), .cw_dm_write_enable(cw_dm_write_enable),
        .state(state), .illegal_instr(illegal_instr), .retire(retire),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Leaves the bench on a falling edge with cycle 0 (FETCH) current.
    task automatic do_reset();
        rst_n = 1'b0; im_ready = 1'b0; dm_ready = 1'b0; im_rdata = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_retire = '0;
    endtask

    task automatic test_reset();
        logic [5:0] strobes;
        rst_n = 1'b0;
        @(negedge clk); #1;
        strobes = {cw_pc_enable, cw_rf_write_enable, cw_dm_write_enable, dm_req, retire, illegal_instr};
        tests_run++;
        if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_state got %0d exp 0", state); end
        tests_run++;
        if (strobes !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_strobes got %b exp 000000", strobes); end
        tests_run++;
        if (retire_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_count got %0d exp 0", retire_count); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        tests_run++;
        if ({im_req, cw_im_enable} !== 2'b11) begin tests_failed++; $display("[TB] FAIL release_im_req got %b exp 11", {im_req, cw_im_enable}); end
        exp_retire = '0;
        #1;
    endtask

    task automatic test_lui();
        im_rdata = 32'h3c011234; im_ready = 1'b1; #1;
        tests_run++;
        if (state !== 3'd0 || im_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL lui_fetch got state=%0d im_req=%b exp 0/1", state, im_req); end
        @(negedge clk); im_ready = 1'b0; #1;
        tests_run++;
        if (state !== 3'd1 || cw_rf_read_addr2 !== 5'd1 || cw_ext_mode !== 3'd1 || cw_alu_op !== 5'd2) begin
            tests_failed++;
            $display("[TB] FAIL lui_decode got state=%0d rt=%0d ext=%0d alu=%0d exp 1/1/1/2", state, cw_rf_read_addr2, cw_ext_mode, cw_alu_op);
        end
        @(negedge clk); #1;
        tests_run++;
        if (state !== 3'd2 || cw_rf_write_enable !== 1'b0 || retire !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lui_exec got state=%0d we=%b retire=%b exp 2/0/0", state, cw_rf_write_enable, retire);
        end
        @(negedge clk); #1;
        tests_run++;
        if (state !== 3'd4 || cw_rf_write_enable !== 1'b1 || cw_rf_write_addr !== 5'd1 || cw_ext_mode !== 3'd1 ||
            cw_alu_op !== 5'd2 || cm_rf_write_data !== 2'd0 || cm_alu_num2 !== 1'b1 || retire !== 1'b1 || cw_pc_enable !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL lui_wb got state=%0d we=%b wa=%0d ext=%0d alu=%0d wd=%0d n2=%b ret=%b pc=%b exp 4/1/1/1/2/0/1/1/1",
                     state, cw_rf_write_enable, cw_rf_write_addr, cw_ext_mode, cw_alu_op, cm_rf_write_data, cm_alu_num2, retire, cw_pc_enable);
        end
        exp_retire++;
        @(negedge clk); #1;
        tests_run++;
        if (state !== 3'd0 || retire_count !== exp_retire) begin
            tests_failed++;
            $display("[TB] FAIL lui_done got state=%0d count=%0d exp 0/%0d", state, retire_count, exp_retire);
        end
        #1;
    endtask

    task automatic test_lw_wait();
        int n_req = 0, n_we = 0, n_ret = 0, ret_cyc = -1;
        logic [4:0] we_addr = '0;
        logic [1:0] we_data = '0;
        for (int c = 0; c < 8; c++) begin
            im_rdata = 32'h8c220004; im_ready = (c == 0); dm_ready = (c == 6); #1;
            if (dm_req) n_req++;
            if (cw_rf_write_enable) begin n_we++; we_addr = cw_rf_write_addr; we_data = cm_rf_write_data; end
            if (retire) begin n_ret++; ret_cyc = c; end
            @(negedge clk);
        end
        im_ready = 1'b0; dm_ready = 1'b0;
        exp_retire++;
        tests_run++;
        if (n_req !== 4) begin tests_failed++; $display("[TB] FAIL lw_dm_req_cycles got %0d exp 4", n_req); end
        tests_run++;
        if (n_we !== 1 || we_addr !== 5'd2 || we_data !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL lw_rf_write got n=%0d wa=%0d wd=%0d exp 1/2/1", n_we, we_addr, we_data);
        end
        tests_run++;
        if (n_ret !== 1 || ret_cyc !== 7) begin tests_failed++; $display("[TB] FAIL lw_latency got n=%0d cyc=%0d exp 1/7", n_ret, ret_cyc); end
        #1;
        tests_run++;
        if (retire_count !== exp_retire) begin tests_failed++; $display("[TB] FAIL lw_count got %0d exp %0d", retire_count, exp_retire); end
    endtask

    task automatic test_sw();
        int n_dmwe = 0, dmwe_cyc = -1, n_we = 0, ret_cyc = -1;
        for (int c = 0; c < 4; c++) begin
            im_rdata = 32'hac220008; im_ready = (c == 0); dm_ready = 1'b1; #1;
            if (cw_dm_write_enable) begin n_dmwe++; dmwe_cyc = c; end
            if (cw_rf_write_enable) n_we++;
            if (retire) ret_cyc = c;
            @(negedge clk);
        end
        im_ready = 1'b0; dm_ready = 1'b0;
        exp_retire++;
        tests_run++;
        if (n_dmwe !== 1 || dmwe_cyc !== 3) begin tests_failed++; $display("[TB] FAIL sw_dm_write got n=%0d cyc=%0d exp 1/3", n_dmwe, dmwe_cyc); end
        tests_run++;
        if (n_we !== 0 || ret_cyc !== 3) begin tests_failed++; $display("[TB] FAIL sw_rf_we_retire got we=%0d ret_cyc=%0d exp 0/3", n_we, ret_cyc); end
    endtask

    task automatic test_jal_illegal();
        logic [4:0] wa = '0;
        logic [1:0] wd = '0;
        logic [2:0] jm = '0;
        logic [3:0] strb = '0;
        int n_ill = 0, n_wr = 0, ret_cyc = -1;
        for (int c = 0; c < 3; c++) begin
            im_rdata = 32'h0c000010; im_ready = (c == 0); #1;
            if (c == 2) begin
                wa = cw_rf_write_addr; wd = cm_rf_write_data; jm = cw_npc_jump_mode;
                strb = {cw_rf_write_enable, cw_pc_enable, retire, state == 3'd2};
            end
            @(negedge clk);
        end
        exp_retire++;
        tests_run++;
        if (wa !== 5'd31 || wd !== 2'd2 || jm !== 3'd2 || strb !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL jal_exec got wa=%0d wd=%0d jump=%0d we/pc/ret/exec=%b exp 31/2/2/1111", wa, wd, jm, strb);
        end
        tests_run++;
        if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL jal_latency got state=%0d exp 0", state); end
        for (int c = 0; c < 3; c++) begin
            im_rdata = 32'hfc000000; im_ready = (c == 0); #1;
            if (illegal_instr) n_ill++;
            if (cw_rf_write_enable || cw_dm_write_enable) n_wr++;
            if (retire) ret_cyc = c;
            @(negedge clk);
        end
        im_ready = 1'b0;
        exp_retire++;
        tests_run++;
        if (n_ill !== 1 || n_wr !== 0 || ret_cyc !== 2) begin
            tests_failed++;
            $display("[TB] FAIL illegal_seq got ill=%0d writes=%0d ret_cyc=%0d exp 1/0/2", n_ill, n_wr, ret_cyc);
        end
        #1;
        tests_run++;
        if (retire_count !== exp_retire) begin tests_failed++; $display("[TB] FAIL illegal_count got %0d exp %0d", retire_count, exp_retire); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [2] = '{32'h00221821, 32'h00222823};
        logic [4:0]  exp_wa [2] = '{5'd3, 5'd5};
        logic [4:0]  exp_alu[2] = '{5'd0, 5'd1};
        logic [4:0]  wa = '0, alu = '0;
        logic        we = 1'b0, n2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                im_rdata = instrs[k]; im_ready = (c == 0); #1;
                if (c == 3) begin wa = cw_rf_write_addr; alu = cw_alu_op; we = cw_rf_write_enable; n2 = cm_alu_num2; end
                @(negedge clk);
            end
            exp_retire++;
            tests_run++;
            if (wa !== exp_wa[k] || alu !== exp_alu[k] || we !== 1'b1 || n2 !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rtype_%0d got wa=%0d alu=%0d we=%b n2=%b exp %0d/%0d/1/0", k, wa, alu, we, n2, exp_wa[k], exp_alu[k]);
            end
        end
        im_ready = 1'b0;
        #1;
        tests_run++;
        if (retire_count !== exp_retire) begin tests_failed++; $display("[TB] FAIL rtype_count got %0d exp %0d", retire_count, exp_retire); end
    endtask

    task automatic test_timeout();
        int n_fetch = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            im_ready = 1'b0; #1;
            if (state == 3'd0 && im_req) n_fetch++;
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (n_fetch !== 16) begin tests_failed++; $display("[TB] FAIL timeout_wait got %0d exp 16", n_fetch); end
        tests_run++;
        if (state !== 3'd7 || {im_req, dm_req, cw_pc_enable, cw_rf_write_enable, cw_dm_write_enable, retire} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_halt got state=%0d req/strobes=%b exp 7/000000", state,
                     {im_req, dm_req, cw_pc_enable, cw_rf_write_enable, cw_dm_write_enable, retire});
        end
        im_ready = 1'b1; im_rdata = 32'h00221821;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (state !== 3'd7) begin tests_failed++; $display("[TB] FAIL halt_sticky got state=%0d exp 7", state); end
        im_ready = 1'b0;
    endtask

    task automatic test_timeout_race();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            im_rdata = 32'h00000000; im_ready = (c == 15);
            @(negedge clk);
        end
        im_ready = 1'b0; #1;
        tests_run++;
        if (state !== 3'd1) begin tests_failed++; $display("[TB] FAIL timeout_race got state=%0d exp 1", state); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid_sw();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            im_rdata = 32'h00000000; im_ready = (c == 0);
            @(negedge clk);
        end
        exp_retire++;
        #1;
        tests_run++;
        if (retire_count !== exp_retire) begin tests_failed++; $display("[TB] FAIL nop_count got %0d exp %0d", retire_count, exp_retire); end
        for (int c = 0; c < 3; c++) begin
            im_rdata = 32'hac220008; im_ready = (c == 0); dm_ready = 1'b0;
            @(negedge clk);
        end
        im_ready = 1'b0; dm_ready = 1'b1; rst_n = 1'b0; #1;
        tests_run++;
        if (cw_dm_write_enable !== 1'b0 || cw_pc_enable !== 1'b0 || retire !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sw_strobes got dmwe=%b pc=%b ret=%b exp 0/0/0", cw_dm_write_enable, cw_pc_enable, retire);
        end
        tests_run++;
        if (state !== 3'd0 || retire_count !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sw_state got state=%0d count=%0d exp 0/0", state, retire_count);
        end
        @(negedge clk);
        rst_n = 1'b1; dm_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lui();
        test_lw_wait();
        test_sw();
        test_jal_illegal();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_reset_mid_sw();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Multi-cycle sequencer for the MIPS-subset datapath (pc, im, rf, alu, ext, dm, npc). It replaces the single-cycle decoder.
- Latches the fetched instruction into an internal IR.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same cw_*/cm_* control words, qualified per state.
- Handshakes with wait-stated instruction and data memories.
- Counts retired instructions and halts on memory timeout.

Parameters:
WAIT_TIMEOUT, 16, max consecutive cycles waiting on im_ready/dm_ready before halting; 0 = never time out
RETIRE_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
im_rdata  in  32  instruction word from im
im_ready  in  1  im_rdata valid this cycle
dm_ready  in  1  dm access completes this cycle
im_req  out  1  instruction fetch request
dm_req  out  1  data access request (lw/sw)
cw_pc_enable  out  1  PC update strobe (one cycle per instruction)
cw_im_enable  out  1  equals im_req
cw_rf_read_addr1  out  5  IR[25:21]
cw_rf_read_addr2  out  5  IR[20:16]
cw_rf_write_addr  out  5  rd / rt / 31 per instruction
cm_rf_write_data  out  2  ALU_RESULT / DM_READ_RESULT / PC_ADD_4
cm_alu_num2  out  1  RF_READ_RESULT2 / EXT_RESULT
cw_npc_jump_mode  out  3  DISABLED / WHEN_EQUAL / JNUM / REG
cw_rf_write_enable  out  1  rf write strobe
cw_alu_op  out  5  ALU_ADD / ALU_SUB / ALU_OR
cw_ext_mode  out  3  UNSIGNED / PAD / SIGNED
cw_dm_write_enable  out  1  dm write strobe
state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7
illegal_instr  out  1  one-cycle pulse in EXEC for an unrecognised opcode/funct
retire  out  1  one-cycle pulse when an instruction completes (same cycle as cw_pc_enable)
retire_count  out  RETIRE_WIDTH  instructions retired since reset; wraps modulo 2^RETIRE_WIDTH

Behaviour:
Reset (rst_n low, async):
- state=FETCH, IR=0, wait counter=0, retire_count=0.
- All strobes 0: cw_pc_enable, cw_rf_write_enable, cw_dm_write_enable, dm_req, retire, illegal_instr.
- im_req and cw_im_enable are 1 as soon as reset releases (FETCH).
- Reset mid-instruction abandons it: no rf/dm/pc strobe may fire in the reset cycle.

Output timing:
- Control words are combinational from state and IR only, never from im_rdata.
- Mux selects and cw_alu_op/cw_ext_mode hold the instruction's decode values in DECODE through WB.
- Strobes assert only in the states listed below.

Decode (from IR):
- ADDU op0/funct 0x21; SUBU op0/funct 0x23; LUI 0x0f; ORI 0x0d; LW 0x23; SW 0x2b; BEQ 0x04; JAL 0x03; JR op0/funct 0x08; JALR op0/funct 0x09.
- NOP is op0/funct 0 (sll).
- Anything else is UNKNOWN: sequenced like NOP, plus illegal_instr.

Per-instruction mux/op values:
- addu: write rd, ALU_RESULT, ALU_ADD, num2=RF.
- subu: write rd, ALU_RESULT, ALU_SUB, num2=RF.
- lui: write rt, ALU_RESULT, ALU_OR, ext PAD, num2=EXT.
- ori: write rt, ALU_RESULT, ALU_OR, ext UNSIGNED, num2=EXT.
- lw: write rt, DM_READ_RESULT, ALU_ADD, ext SIGNED, num2=EXT.
- sw: ALU_ADD, ext SIGNED, num2=EXT.
- beq: jump WHEN_EQUAL, num2=RF.
- jal: write 31, PC_ADD_4, jump JNUM.
- jalr: write rd, PC_ADD_4, jump REG.
- jr: jump REG.
- Defaults: write addr rt, ALU_OR, ext UNSIGNED, jump DISABLED.

Transitions:
- FETCH: im_req=1. When im_ready, load IR<=im_rdata and go to DECODE; otherwise stay.
- DECODE: 1 cycle, then EXEC.
- EXEC, addu/subu/lui/ori: go to WB.
- EXEC, lw/sw: go to MEM.
- EXEC, beq/jr/nop/unknown: cw_pc_enable=1, retire=1, go to FETCH.
- EXEC, jal/jalr: cw_rf_write_enable=1, cw_pc_enable=1, retire=1, go to FETCH.
- MEM: dm_req=1 until dm_ready.
  - sw: cw_dm_write_enable=1 in the dm_ready cycle only, plus cw_pc_enable and retire, then FETCH.
  - lw: on dm_ready go to WB.
- WB: cw_rf_write_enable=1, cw_pc_enable=1, retire=1, go to FETCH.
- Zero-wait latencies: addu/subu/lui/ori/sw 4 cycles; lw 5; beq/jr/jal/jalr/nop 3.

Wait and timeout:
- The wait counter increments each cycle in FETCH/MEM while ready is low and clears when ready is seen or the state is left.
- If WAIT_TIMEOUT≠0 and the counter reaches WAIT_TIMEOUT, go to HALT.
- HALT: all strobes 0, im_req=0, dm_req=0; exit only via reset.
- A ready arriving in the same cycle the counter reaches the limit wins: no halt.

Counter:
- retire_count increments by 1 on each retire; all-ones wraps to 0.

Test Plan:
- Reset, im_ready=1, im_rdata=0x3c011234 (lui $1,0x1234) -> IR loaded in cycle 0; WB in cycle 3 with cw_rf_write_enable=1, write addr 1, ext PAD, ALU_OR; retire_count=1.
- lw 0x8c220004 with dm_ready low 3 cycles -> dm_req held 4 cycles; rf write to $2 with DM_READ_RESULT exactly once; total 8 cycles.
- sw 0xac220008, dm_ready=1 -> cw_dm_write_enable high exactly 1 cycle (cycle 3); cw_rf_write_enable never 1.
- jal 0x0c000010 -> EXEC cycle has write addr 31, PC_ADD_4, JNUM, rf_we=1, pc_enable=1; 3 cycles total. Then 0xfc000000 -> illegal_instr pulse, no rf/dm write, retire.
- im_ready held 0, WAIT_TIMEOUT=16 -> state=7 after 16 wait cycles with all strobes 0. Repeat with im_ready rising at the limit cycle -> no halt.
- Assert rst_n low during MEM of sw (dm_ready=1 that cycle) -> no dm write, state=FETCH, retire_count=0.
